// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller.
// Picks pseudo-random mole positions, scores hits and expired moles, and runs
// the round countdown from the 1 Hz strobe.
// Optional build macro: MOLE_PENALTY_EN (wrong-button presses cost one point).
module mole_game_ctrl #(
    parameter int unsigned NUM_MOLES  = 8,
    parameter int unsigned ROUND_SECS = 60,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk_orig,
    input  logic                 rst,
    input  logic                 tick_1hz,
    input  logic                 clk_lev,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit_btn,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic [7:0]           score,
    output logic [7:0]           misses,
    output logic [6:0]           time_left,
    output logic                 game_over
);

    localparam int unsigned PosW = $clog2(NUM_MOLES);

    typedef enum logic [1:0] {
        StIdle,
        StSpawn,
        StUp,
        StOver
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q;
    logic [15:0]            lfsr_d;
    logic                   lev_q;
    logic [PosW-1:0]        last_pos_q, last_pos_d;
    logic [NUM_MOLES-1:0]   mole_q, mole_d;
    logic [7:0]             score_q, score_d;
    logic [7:0]             misses_q, misses_d;
    logic [6:0]             time_q, time_d;

    logic                   lev_step;
    logic [PosW-1:0]        pos_raw;
    logic [PosW-1:0]        pos_spawn;
    logic                   hit_ok;
    logic                   hit_wrong;
    logic [NUM_MOLES-1:0]   last_onehot;

    // Galois LFSR (taps 16,14,13,11) and level-edge detect, free running.
    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        lev_step  = clk_lev ^ lev_q;
        pos_raw   = lfsr_q[PosW-1:0];
        // Power-of-two mole count, so the +1 wraps modulo NUM_MOLES for free.
        pos_spawn = (pos_raw == last_pos_q) ? pos_raw + PosW'(1) : pos_raw;
        last_onehot = NUM_MOLES'(1) << last_pos_q;
        hit_ok      = hit_btn[last_pos_q];
        hit_wrong   = |(hit_btn & ~last_onehot);
    end

    // Next-state and counter update; timer expiry and start override the FSM moves.
    always_comb begin
        state_d    = state_q;
        last_pos_d = last_pos_q;
        mole_d     = mole_q;
        score_d    = score_q;
        misses_d   = misses_q;
        time_d     = time_q;

        unique case (state_q)
            StIdle: begin
                mole_d = '0;
            end
            StSpawn: begin
                mole_d     = NUM_MOLES'(1) << pos_spawn;
                last_pos_d = pos_spawn;
                state_d    = StUp;
            end
            StUp: begin
                if (hit_ok) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    mole_d  = '0;
                    state_d = StSpawn;
                end else begin
`ifdef MOLE_PENALTY_EN
                    if (hit_wrong && (score_q != 8'd0)) begin
                        score_d = score_q - 8'd1;
                    end
`endif
                    if (lev_step) begin
                        misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
                        mole_d   = '0;
                        state_d  = StSpawn;
                    end
                end
            end
            StOver: begin
                mole_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q == StSpawn || state_q == StUp) && tick_1hz) begin
            time_d = time_q - 7'd1;
            if (time_q == 7'd1) begin
                state_d = StOver;
                mole_d  = '0;
            end
        end

        // start from any state begins a fresh round
        if (start) begin
            score_d  = 8'd0;
            misses_d = 8'd0;
            time_d   = 7'(ROUND_SECS);
            mole_d   = '0;
            state_d  = StSpawn;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_orig) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            lev_q      <= 1'b0;
            last_pos_q <= '0;
            mole_q     <= '0;
            score_q    <= 8'd0;
            misses_q   <= 8'd0;
            time_q     <= 7'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            lev_q      <= clk_lev;
            last_pos_q <= last_pos_d;
            mole_q     <= mole_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
            time_q     <= time_d;
        end
    end

    assign mole_led  = mole_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign time_left = time_q;
    assign game_over = (state_q == StOver);

endmodule
